bitonic_frame_packer: RTL

//   Upstream feeder for the two-stage 8-input bitonic sorter. Collects a serial

---
 rtl/bitonic_frame_packer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bitonic_frame_packer.sv
// bitonic_frame_packer
//   Front end for the two-stage 8-input bitonic sorter. It gathers a serial
//   stream of signed samples (valid/ready handshake) into 8-sample frames and
//   presents each frame on lanes a..h. A frame is held on a..h until downstream
//   takes the sorted result. The packer mirrors the sorter's one-cycle
//   register, so sort_valid is high exactly while the sorter outputs i..p hold
//   the sorted current frame. The next frame is collected while the current
//   one is settling or waiting.
//
//   Optional feature: define PACKER_FLUSH_EN to add the in_last port. A burst
//   that ends part-way through a frame is then padded with the most negative
//   value and released as a full frame.
//
// Ports
//   clk         clock
//   rst_n       asynchronous, active-low reset
//   in_data     signed input sample (N bits)
//   in_valid    in_data valid
//   in_ready    packer accepts in_data this cycle
//   in_last     last sample of a burst (PACKER_FLUSH_EN builds only)
//   a..h        frame lanes to the sorter; a is the oldest sample
//   sort_valid  sorter outputs i..p hold the sorted current frame
//   sort_ready  downstream has taken i..p; frees the frame
//   frame_cnt   number of frames released, wraps modulo 2^CNT_W
module bitonic_frame_packer #(
  parameter int N     = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef PACKER_FLUSH_EN
  input  logic             in_last,
`endif
  output logic [N-1:0]     a,
  output logic [N-1:0]     b,
  output logic [N-1:0]     c,
  output logic [N-1:0]     d,
  output logic [N-1:0]     e,
  output logic [N-1:0]     f,
  output logic [N-1:0]     g,
  output logic [N-1:0]     h,
  output logic             sort_valid,
  input  logic             sort_ready,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_VALID  = 2'd2;

  // Pad value for flushed frames: it sorts to the lowest sorter outputs.
  localparam logic signed [N-1:0] PAD = {1'b1, {(N-1){1'b0}}};

  logic [2:0]          cnt;
  logic                coll_full;
  logic [1:0]          frame_state;
  logic signed [N-1:0] coll_p0 [8];
  logic signed [N-1:0] lane_p1 [8];
  logic                accept;
  logic                flush;
  logic                release_frame;
  logic                load;

  assign in_ready = rst_n & ~coll_full;
  assign accept   = in_valid & in_ready;

`ifdef PACKER_FLUSH_EN
  // in_last on the eighth sample is just a normal frame end.
  assign flush = accept & in_last & (cnt != 3'd7);
`else
  assign flush = 1'b0;
`endif

  assign sort_valid    = (frame_state == ST_VALID);
  assign release_frame = sort_valid & sort_ready;
  // The collect buffer moves into the lanes when no frame is held, or when
  // the held frame is released in the same cycle. That second case gives
  // back-to-back frames with no gap.
  assign load = coll_full & ((frame_state == ST_EMPTY) | release_frame);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 3'd0;
      coll_full   <= 1'b0;
      frame_state <= ST_EMPTY;
      frame_cnt   <= '0;
    end else begin
      // accept needs coll_full low and load needs it high, so the two
      // branches never fire in the same cycle.
      if (accept) begin
        if ((cnt == 3'd7) || flush) begin
          cnt       <= 3'd0;
          coll_full <= 1'b1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end else if (load) begin
        coll_full <= 1'b0;
      end

      case (frame_state)
        ST_EMPTY:  if (load) frame_state <= ST_SETTLE;
        ST_SETTLE: frame_state <= ST_VALID;
        ST_VALID: begin
          if (release_frame) begin
            frame_cnt   <= frame_cnt + 1'b1;
            frame_state <= load ? ST_SETTLE : ST_EMPTY;
          end
        end
        default:   frame_state <= ST_EMPTY;
      endcase
    end
  end

  // ---- stage p0: collect buffer (contents are meaningless until coll_full)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (accept) begin
        if (3'(i) == cnt) begin
          coll_p0[i] <= in_data;
        end else if (flush && (3'(i) > cnt)) begin
          coll_p0[i] <= PAD;
        end
      end
    end
  end

  // ---- stage p1: frame lanes held for the sorter, changed only on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) lane_p1[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 8; i++) lane_p1[i] <= coll_p0[i];
    end
  end

  assign a = lane_p1[0];
  assign b = lane_p1[1];
  assign c = lane_p1[2];
  assign d = lane_p1[3];
  assign e = lane_p1[4];
  assign f = lane_p1[5];
  assign g = lane_p1[6];
  assign h = lane_p1[7];

endmodule
